// File: rtl/dot_pkg.sv
// Shared constants, FSM state type and score saturation helper for the dot/score block.
package dot_pkg;

  localparam int NUM_DOTS  = 32;
  localparam int DOT_CNT_W = 6;
  localparam int SCORE_W   = 16;
  localparam int LEVEL_W   = 4;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RESTART = 2'd2
  } dot_score_state_t;

  // Adds a 32-bit increment to the score, pinning at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                 input logic [31:0]        add);
    logic [32:0] sum;
    sum = {17'b0, base} + {1'b0, add};
    if (sum > 33'({SCORE_W{1'b1}})) return '1;
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/dot_popcount.sv
// Combinational population count of the 32 dot flags.
module dot_popcount
  import dot_pkg::*;
(
  input  logic [NUM_DOTS-1:0]  i_bits,
  output logic [DOT_CNT_W-1:0] o_count
);

  always_comb begin
    // NOTE: blocking '=' is intentional here; each iteration must see the previous partial sum.
    o_count = '0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      o_count = o_count + DOT_CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/dot_score.sv
// Score, dot count and level sequencing for the maze game.
// Optional level-clear bonus enabled by defining DOT_SCORE_BONUS_EN.
module dot_score
  import dot_pkg::*;
#(
  parameter int unsigned POINTS_PER_DOT = 10,
  parameter int unsigned CLEAR_FRAMES   = 120,
  parameter int unsigned LEVEL_BONUS    = 500
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_DOTS-1:0]  eaten,
  input  logic                 frame_tick,
  output logic [SCORE_W-1:0]   score,
  output logic [DOT_CNT_W-1:0] dots_remaining,
  output logic [LEVEL_W-1:0]   level,
  output logic                 level_clear,
  output logic                 level_reset
);

`ifdef DOT_SCORE_BONUS_EN
  localparam logic [31:0] BONUS_PTS = 32'(LEVEL_BONUS);
`else
  localparam logic [31:0] BONUS_PTS = 32'(LEVEL_BONUS) * 32'd0;
`endif

  dot_score_state_t      r_state;
  dot_score_state_t      w_state_nxt;
  logic [NUM_DOTS-1:0]   r_eaten_q;
  logic [7:0]            r_frame_cnt;
  logic [NUM_DOTS-1:0]   w_new;
  logic [DOT_CNT_W-1:0]  w_new_cnt;
  logic [DOT_CNT_W-1:0]  w_eaten_cnt;
  logic                  w_all_eaten;
  logic                  w_last_frame;
  logic [31:0]           w_add;

  // Only 0->1 transitions score; a dot that reappears and is eaten again scores again.
  assign w_new        = eaten & ~r_eaten_q;
  assign w_all_eaten  = &eaten;
  assign w_last_frame = (r_frame_cnt == 8'(CLEAR_FRAMES - 1));

  dot_popcount u_pop_new   (.i_bits(w_new), .o_count(w_new_cnt));
  dot_popcount u_pop_eaten (.i_bits(eaten), .o_count(w_eaten_cnt));

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    w_state_nxt = r_state;
    w_add       = '0;
    case (r_state)
      ST_PLAY: begin
        w_add = 32'(w_new_cnt) * POINTS_PER_DOT;
        if (w_all_eaten) begin
          w_state_nxt = ST_CLEAR;
          w_add       = w_add + BONUS_PTS;
        end
      end
      ST_CLEAR:   if (frame_tick && w_last_frame) w_state_nxt = ST_RESTART;
      ST_RESTART: w_state_nxt = ST_PLAY;
      default:    w_state_nxt = ST_PLAY;
    endcase
  end

  // NOTE: non-blocking '<=' for all state so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= ST_PLAY;
      r_eaten_q      <= '0;
      r_frame_cnt    <= '0;
      score          <= '0;
      dots_remaining <= DOT_CNT_W'(NUM_DOTS);
      level          <= '0;
      level_clear    <= 1'b0;
      level_reset    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_eaten_q      <= eaten;
      dots_remaining <= DOT_CNT_W'(NUM_DOTS) - w_eaten_cnt;
      score          <= sat_add(score, w_add);
      // Flags track the next state so they line up exactly with the registered state.
      level_clear    <= (w_state_nxt == ST_CLEAR);
      level_reset    <= (w_state_nxt == ST_RESTART);
      if (r_state == ST_CLEAR && frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (r_state == ST_RESTART) begin
        r_frame_cnt <= '0;
      end
      if (r_state == ST_RESTART && level != '1) begin
        level <= level + 1'b1;
      end
    end
  end

endmodule
